imm_target_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/imm_decode.sv | 59 +++++
 rtl/imm_target_unit.sv | 133 +++++++++++++
 tb/tb_imm_target_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32 decode definitions.
//   * XLEN_DEFAULT : default datapath width for the immediate/target units.
//   * OPC_*        : major opcode values (instruction[6:0]).
//   * FMT_*        : instruction format codes reported on the fmt output.
//   * imm_* helpers: extract each format's immediate as a 32-bit value with
//                    instruction[31] replicated into every upper bit.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_SB = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_UJ = 3'd5;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode -- purely combinational RV32 immediate decoder.
// Ports:
//   instruction [31:0]   : instruction word
//   immediate [XLEN-1:0] : immediate, sign-extended from instruction[31]
//   fmt [2:0]            : format code (FMT_* from riscv_pkg)
//   illegal              : opcode not recognised (fmt=R, immediate=0)
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (instruction[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                imm32 = imm_i(instruction);
                fmt   = FMT_I;
            end
            OPC_STORE: begin
                imm32 = imm_s(instruction);
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = imm_b(instruction);
                fmt   = FMT_SB;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = imm_u(instruction);
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = imm_j(instruction);
                fmt   = FMT_UJ;
            end
            OPC_OP: begin
                imm32 = '0;
                fmt   = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit helper already carries instruction[31] in bit 31, so a
    // signed size cast finishes the extension for XLEN=64.
    assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_target_unit.sv
// imm_target_unit -- two-stage elastic pipeline that decodes an RV32
// instruction's immediate and computes pc + immediate.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake
//   instruction [31:0], pc : input beat
//   flush                  : drop every in-flight beat on the next edge
//   out_valid / out_ready  : output handshake
//   immediate, target      : sign-extended immediate, pc + immediate
//   fmt [2:0], illegal     : format code, unrecognised opcode flag
//   ill_count [CNT_W-1:0]  : saturating count of delivered illegal beats
// For jalr the target is only pc + imm; rs1 is added further downstream.
module imm_target_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immediate,
    output logic [XLEN-1:0]  target,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_count
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic             vld_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [XLEN-1:0]  pc_p1;
    logic [2:0]       fmt_p1;
    logic             ill_p1;

    logic             vld_p2;
    logic [XLEN-1:0]  imm_p2;
    logic [XLEN-1:0]  tgt_p2;
    logic [2:0]       fmt_p2;
    logic             ill_p2;

    logic [CNT_W-1:0] ill_cnt;
    logic             load_p2;
    logic             take_in;
    logic             give_out;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .immediate   (dec_imm),
        .fmt         (dec_fmt),
        .illegal     (dec_ill)
    );

    // Stage 2 can take a beat when empty or when its beat leaves this cycle;
    // stage 1 likewise when empty or when it moves into stage 2.
    assign load_p2  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || load_p2;
    assign take_in  = in_valid && in_ready;
    assign give_out = vld_p2 && out_ready;

    // ---- stage 1: decoded immediate, fmt, illegal, pc ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            pc_p1  <= '0;
            fmt_p1 <= FMT_R;
            ill_p1 <= 1'b0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (take_in) begin
                imm_p1 <= dec_imm;
                pc_p1  <= pc;
                fmt_p1 <= dec_fmt;
                ill_p1 <= dec_ill;
            end
        end
    end

    // ---- stage 2: target, immediate, fmt, illegal ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            imm_p2 <= '0;
            tgt_p2 <= '0;
            fmt_p2 <= FMT_R;
            ill_p2 <= 1'b0;
        end else begin
            if (flush) begin
                vld_p2 <= 1'b0;
            end else if (load_p2) begin
                vld_p2 <= vld_p1;
            end
            // Data only moves with a real beat, so held outputs stay stable.
            if (vld_p1 && load_p2) begin
                imm_p2 <= imm_p1;
                tgt_p2 <= pc_p1 + imm_p1;
                fmt_p2 <= fmt_p1;
                ill_p2 <= ill_p1;
            end
        end
    end

    // ---- delivery accounting: a beat handed over during flush still counts ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt <= '0;
        end else if (give_out && ill_p2 && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

    assign out_valid = vld_p2;
    assign immediate = imm_p2;
    assign target    = tgt_p2;
    assign fmt       = fmt_p2;
    assign illegal   = ill_p2;
    assign ill_count = ill_cnt;

endmodule

// File: tb/tb_imm_target_unit.sv
module tb_imm_target_unit;

    localparam int TB_XLEN  = 32;
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
    localparam int NV       = 15;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instruction;
    logic [TB_XLEN-1:0]  pc;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [TB_XLEN-1:0]  immediate;
    logic [TB_XLEN-1:0]  target;
    logic [2:0]          fmt;
    logic                illegal;
    logic [TB_CNT_W-1:0] ill_count;

    imm_target_unit #(.XLEN(TB_XLEN), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc          (pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .immediate   (immediate),
        .target      (target),
        .fmt         (fmt),
        .illegal     (illegal),
        .ill_count   (ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic [31:0] v_inst [NV];
    logic [31:0] v_pc   [NV];
    exp_t        v_exp  [NV];

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;
    int   cur_k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic set_vec(input int k, input logic [31:0] inst, input logic [31:0] p,
                           input logic [31:0] imm, input logic [31:0] tgt,
                           input logic [2:0] f, input logic il);
        v_inst[k] = inst;
        v_pc[k]   = p;
        v_exp[k]  = '{imm: imm, tgt: tgt, fmt: f, ill: il};
    endtask

    task automatic drive(input int k);
        cur_k       = k;
        in_valid    = 1'b1;
        instruction = v_inst[k];
        pc          = v_pc[k];
    endtask

    // One clock: the expectation is queued at the moment the beat is taken.
    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !flush && !reset;
        if (acc) q.push_back(v_exp[cur_k]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        repeat (n) tick(a);
    endtask

    // Monitor: every presented result is checked against the queue head,
    // which also covers stability while out_ready is low.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ill_count", 64'(ill_count), 64'(exp_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    chk("immediate", 64'(immediate), 64'(q[0].imm));
                    chk("target",    64'(target),    64'(q[0].tgt));
                    chk("fmt",       64'(fmt),       64'(q[0].fmt));
                    chk("illegal",   64'(illegal),   64'(q[0].ill));
                    if (out_ready) begin
                        if (q[0].ill && exp_cnt < CNT_MAX) exp_cnt++;
                        void'(q.pop_front());
                    end
                end
            end
            if (flush) q.delete();
        end
    end

    initial begin : main
        bit acc;
        int n;
        int guard;
        int stream_k [12];
        int bp_k [3];

        set_vec(0,  32'hFFF00093, 32'h100,      32'hFFFFFFFF, 32'h000000FF, 3'd1, 1'b0);
        set_vec(1,  32'hFE000FE3, 32'h200,      32'hFFFFFFFE, 32'h000001FE, 3'd3, 1'b0);
        set_vec(2,  32'hFE000EE3, 32'h200,      32'hFFFFFFFC, 32'h000001FC, 3'd3, 1'b0);
        set_vec(3,  32'h123452B7, 32'h0,        32'h12345000, 32'h12345000, 3'd4, 1'b0);
        set_vec(4,  32'h0080006F, 32'h1000,     32'h00000008, 32'h00001008, 3'd5, 1'b0);
        set_vec(5,  32'h00112423, 32'h10,       32'h00000008, 32'h00000018, 3'd2, 1'b0);
        set_vec(6,  32'hFE112E23, 32'h10,       32'hFFFFFFFC, 32'h0000000C, 3'd2, 1'b0);
        set_vec(7,  32'h002081B3, 32'h20,       32'h00000000, 32'h00000020, 3'd0, 1'b0);
        set_vec(8,  32'hFFFFF117, 32'h3000,     32'hFFFFF000, 32'h00002000, 3'd4, 1'b0);
        set_vec(9,  32'h00C08067, 32'h500,      32'h0000000C, 32'h0000050C, 3'd1, 1'b0);
        set_vec(10, 32'h80002003, 32'h1000,     32'hFFFFF800, 32'h00000800, 3'd1, 1'b0);
        set_vec(11, 32'h000010B7, 32'hFFFFFFF0, 32'h00001000, 32'h00000FF0, 3'd4, 1'b0);
        set_vec(12, 32'h0000007F, 32'h40,       32'h00000000, 32'h00000040, 3'd0, 1'b1);
        set_vec(13, 32'hFFFFFFFF, 32'h80,       32'h00000000, 32'h00000080, 3'd0, 1'b1);
        set_vec(14, 32'hFF9FF06F, 32'h2000,     32'hFFFFFFF8, 32'h00001FF8, 3'd5, 1'b0);

        stream_k = '{3, 4, 1, 2, 5, 6, 7, 8, 9, 10, 11, 14};
        bp_k     = '{3, 4, 5};

        in_valid    = 1'b0;
        instruction = '0;
        pc          = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_immediate", 64'(immediate), 64'd0);
        chk("rst_target",    64'(target),    64'd0);
        chk("rst_fmt",       64'(fmt),       64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_ill_count", 64'(ill_count), 64'd0);
        reset = 1'b0;
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // latency: result visible in the second cycle after the transfer
        drive(0);
        tick(acc);
        chk("lat_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        chk("lat_cycle1_empty", 64'(out_valid), 64'd0);
        tick(acc);
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        idle(3);

        // back-to-back stream at full rate
        foreach (stream_k[i]) begin
            drive(stream_k[i]);
            tick(acc);
            chk("stream_accept", 64'(acc), 64'd1);
        end
        idle(4);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // back-pressure: 3 beats offered over 4 stalled cycles
        out_ready = 1'b0;
        n = 0;
        repeat (4) begin
            drive(bp_k[n]);
            tick(acc);
            if (acc) n++;
        end
        chk("bp_accepted", 64'(n), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        guard = 0;
        while (n < 3 && guard < 10) begin
            drive(bp_k[n]);
            tick(acc);
            if (acc) n++;
            guard++;
        end
        chk("bp_all_accepted", 64'(n), 64'd3);
        idle(5);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // illegal opcode delivered once
        drive(12);
        tick(acc);
        idle(4);
        chk("ill_first", 64'(ill_count), 64'd1);

        // flush with two illegal beats in flight and an input in the same cycle
        out_ready = 1'b0;
        drive(13);
        tick(acc);
        drive(12);
        tick(acc);
        drive(0);
        flush = 1'b1;
        tick(acc);
        chk("flush_input_taken", 64'(acc), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        idle(4);
        chk("flush_count_same", 64'(ill_count), 64'd1);

        // flush coinciding with delivery of an illegal beat
        out_ready = 1'b0;
        drive(12);
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        chk("flushdel_presented", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick(acc);
        flush = 1'b0;
        chk("flushdel_out_valid", 64'(out_valid), 64'd0);
        idle(3);
        chk("flushdel_counted", 64'(ill_count), 64'd2);

        // saturation of the narrow counter
        drive(13);
        tick(acc);
        drive(12);
        tick(acc);
        idle(5);
        chk("ill_saturated", 64'(ill_count), 64'(CNT_MAX));

        // reset mid-operation wins over flush and input
        out_ready = 1'b0;
        drive(3);
        tick(acc);
        drive(4);
        tick(acc);
        drive(5);
        reset = 1'b1;
        flush = 1'b1;
        q.delete();
        exp_cnt = 0;
        tick(acc);
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_immediate", 64'(immediate), 64'd0);
        chk("midrst_target",    64'(target),    64'd0);
        chk("midrst_ill_count", 64'(ill_count), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        drive(0);
        tick(acc);
        idle(4);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
